// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if: request handshakes, result pulse and per-channel hold buses of the shared BCD converter
interface bcd_conv_sched_if #(parameter int W = 16, parameter int DIGITS = 5);
  logic                req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]        req0_bin, req1_bin;
  logic                busy, res_valid, res_ch;
  logic [4*DIGITS-1:0] res_bcd, hold0_bcd, hold1_bcd;
  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin,
    input  req0_ready, req1_ready, busy, res_valid, res_ch, res_bcd, hold0_bcd, hold1_bcd
  );
  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin,
    output req0_ready, req1_ready, busy, res_valid, res_ch, res_bcd, hold0_bcd, hold1_bcd
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin shared serial shift-add-3 binary-to-BCD engine for two requesters.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits (never digit0) with 4'hF.
module bcd_conv_sched #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input logic             clk,
  input logic             rst,
  bcd_conv_sched_if.slave bus
);
  localparam int IW = W > 1 ? $clog2(W) : 1;
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state_q, state_d;
  logic            last_q, last_d, ch_q, ch_d, res_valid_q, res_valid_d, res_ch_q, res_ch_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [BW-1:0]   acc_q, acc_d, res_q, res_d, hold0_q, hold0_d, hold1_q, hold1_d, adj, fmt;
  logic            grant, hs;
  always_comb begin
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = acc_q[4*k+:4] > 4'd4 ? acc_q[4*k+:4] + 4'd3 : acc_q[4*k+:4];
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Walk down from the top digit; blanking stops at the first nonzero digit.
  always_comb begin
    fmt  = acc_q;
    lead = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lead = lead & (acc_q[4*k+:4] == 4'd0);
      if (lead) fmt[4*k+:4] = 4'hF;
    end
  end
`else
  assign fmt = acc_q;
`endif
  assign grant          = bus.req0_valid & bus.req1_valid ? ~last_q : bus.req1_valid;
  assign hs             = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign bus.req0_ready = hs & ~grant;
  assign bus.req1_ready = hs & grant;
  assign bus.busy       = state_q != IDLE;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.res_bcd    = res_q;
  assign bus.hold0_bcd  = hold0_q;
  assign bus.hold1_bcd  = hold1_q;
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    ch_d        = ch_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_d       = res_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    case (state_q)
      IDLE: if (hs) begin
        bin_d   = grant ? bus.req1_bin : bus.req0_bin;
        acc_d   = '0;
        last_d  = grant;
        ch_d    = grant;
        iter_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d   = {adj[BW-2:0], bin_q[W-1]};
        bin_d   = bin_q << 1;
        iter_d  = iter_q + IW'(1);
        state_d = iter_q == IW'(W - 1) ? DONE : SHIFT;
      end
      DONE: begin
        res_valid_d = 1'b1;
        res_ch_d    = ch_q;
        res_d       = fmt;
        hold0_d     = ch_q ? hold0_q : fmt;
        hold1_d     = ch_q ? fmt : hold1_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      ch_q        <= 1'b0;
      bin_q       <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= 1'b0;
      res_q       <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      ch_q        <= ch_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_q       <= res_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
    end
  end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed plus random conversions checked against an arithmetic decimal-digit model
module tb_bcd_conv_sched;
  localparam int W = 16, DIGITS = 5;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  bcd_conv_sched_if #(.W(W), .DIGITS(DIGITS)) bus();
  bcd_conv_sched #(.W(W), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0;
  logic [19:0] hold_m [2];

  function automatic logic [19:0] bcd_ref(input int v);
    logic [19:0] r;
    int p, d;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = (v / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) d = 15;
`endif
      r[4*k+:4] = d[3:0];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.req0_valid = 0; bus.req1_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_ch", bus.res_ch, 0);
    chk("rst_res_bcd", bus.res_bcd, 0);
    chk("rst_hold0", bus.hold0_bcd, 0);
    chk("rst_hold1", bus.hold1_bcd, 0);
    rst = 0;
    hold_m[0] = '0; hold_m[1] = '0;
  endtask

  task automatic wait_result(input bit ch, input logic [19:0] e);
    int n;
    bit found;
    n = 0; found = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      found = bus.res_valid;
      if (!found) chk("busy", bus.busy, 1);
    end
    chk("latency", n, W + 2);
    chk("res_ch", bus.res_ch, ch);
    chk("res_bcd", bus.res_bcd, e);
  endtask

  task automatic convert(input bit ch, input int v);
    int n;
    logic [19:0] e;
    int junk;
    @(negedge clk);
    if (ch) begin bus.req1_valid = 1; bus.req1_bin = v[15:0]; end
    else    begin bus.req0_valid = 1; bus.req0_bin = v[15:0]; end
    #1;
    n = 0;
    while (!(ch ? bus.req1_ready : bus.req0_ready) && n < 50) begin @(negedge clk); #1; n++; end
    chk("ready_wait", n, 0);
    chk("ready_other", ch ? bus.req0_ready : bus.req1_ready, 0);
    @(posedge clk);
    #1;
    junk = $urandom;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_bin = junk[15:0]; bus.req1_bin = junk[31:16];
    e = bcd_ref(v);
    hold_m[ch] = e;
    wait_result(ch, e);
    chk("hold0", bus.hold0_bcd, hold_m[0]);
    chk("hold1", bus.hold1_bcd, hold_m[1]);
    @(negedge clk);
    chk("pulse_end", bus.res_valid, 0);
    chk("res_retain", bus.res_bcd, e);
  endtask

  initial begin
    int n, rv;
    bit seen;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_bin = '0; bus.req1_bin = '0;
    do_reset();
    convert(0, 1234);
    convert(1, 65535);
    convert(1, 0);
    convert(1, 9999);
    convert(0, 42);
    convert(0, 10005);
    convert(1, 10);
    // Contention: both held valid, grants must alternate starting with channel 0.
    do_reset();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_bin = 16'd7;
    bus.req1_valid = 1; bus.req1_bin = 16'd300;
    for (int g = 0; g < 3; g++) begin
      #1;
      n = 0;
      while (!(bus.req0_ready | bus.req1_ready) && n < 50) begin @(negedge clk); #1; n++; end
      chk("tie_ready_wait", n, 0);
      chk("tie_onehot", bus.req0_ready & bus.req1_ready, 0);
      chk("tie_grant", bus.req1_ready, g % 2);
      @(posedge clk);
      hold_m[g % 2] = bcd_ref(g % 2 ? 300 : 7);
      wait_result(g % 2, hold_m[g % 2]);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("tie_hold0", bus.hold0_bcd, bcd_ref(7));
    chk("tie_hold1", bus.hold1_bcd, bcd_ref(300));
    // Reset in the 8th shift cycle aborts the conversion.
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_bin = 16'd4321;
    #1;
    chk("abort_ready", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_hold0", bus.hold0_bcd, 0);
    chk("abort_hold1", bus.hold1_bcd, 0);
    rst = 0;
    hold_m[0] = '0; hold_m[1] = '0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= bus.res_valid; end
    chk("abort_no_result", seen, 0);
    convert(0, 4321);
    convert(1, 9);
    for (int i = 0; i < 30; i++) begin
      rv = $urandom_range(0, 65535);
      if (i % 7 == 0) rv = $urandom_range(0, 120);
      convert($urandom_range(0, 1) == 1, rv);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
